psram_arb: RTL and testbench
============================

PSRAM_ARB -- requirements
Module: psram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 22: PSRAM word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 8: number of consecutive port-0 grants allowed while port 1 waits (used only with PSRAM_ARB_STARVE_EN).
REQ-003 SHALL have port clk  input  1  clock for all logic.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports p0_req / p1_req  input  1  burst request, held until grant.
REQ-006 SHALL have ports p0_addr / p1_addr  input  ADDR_W  burst start address.
REQ-007 SHALL have ports p0_wr / p1_wr  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have ports p0_gnt / p1_gnt  output  1  one-cycle pulse: command accepted by controller.
REQ-009 SHALL have ports p0_done / p1_done  output  1  one-cycle pulse: burst completed.
REQ-010 SHALL have port ctl_valid  output  1  command valid to PSRAM controller.
REQ-011 SHALL have port ctl_ready  input  1  controller accepts command.
REQ-012 SHALL have ports ctl_addr  output  ADDR_W and ctl_wr  output  1  latched command fields.
REQ-013 SHALL have port ctl_done  input  1  one-cycle pulse from controller at end of burst (CE# deasserted).
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT.
REQ-016 In IDLE, when either request is high, SHALL latch winner, its addr and wr, and move to ISSUE next cycle; ctl_valid SHALL be high the cycle after the winning request is sampled.
REQ-017 Without starvation guard, port 0 (display refill) SHALL have fixed priority over port 1.
REQ-018 In ISSUE, ctl_valid SHALL stay high with ctl_addr/ctl_wr stable until ctl_ready is sampled high; on that edge SHALL pulse the winner's pN_gnt for one cycle and move to WAIT.
REQ-019 In WAIT, on ctl_done SHALL pulse the winner's pN_done for one cycle and return to IDLE; re-arbitration occurs in IDLE the following cycle (minimum one idle cycle between bursts).
REQ-020 Requests dropped after latching SHALL NOT abort the command; burst completes normally.
REQ-021 ctl_done sampled in IDLE or ISSUE SHALL be ignored.
REQ-022 ctl_valid SHALL be low in IDLE and WAIT; gnt and done pulses SHALL never be asserted for both ports in the same cycle.

Reset
REQ-023 On reset assertion SHALL enter IDLE immediately; ctl_valid, busy, all gnt/done = 0; ctl_addr = 0; ctl_wr = 0; starvation counter = 0.
REQ-024 Reset mid-burst SHALL discard the command with no done pulse; the controller is reset by the same signal.

Configuration
REQ-025 Macro PSRAM_ARB_STARVE_EN defined: counter increments on each port-0 grant while p1_req is high, clears on port-1 grant or when p1_req is low, saturates at STARVE_MAX; when counter == STARVE_MAX and both request, port 1 SHALL win.
REQ-026 Macro undefined: no counter logic; strict port-0 priority (REQ-017).

Structure
REQ-027 Shared package psram_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, WAIT=2) and default ADDR_W constant.
REQ-028 Single flat module; no sub-module required.

Verification
REQ-029 Single request: p1_req=1, p1_addr=0x00100, p1_wr=1, ctl_ready tied 1 -> ctl_valid next cycle with addr 0x00100, wr=1; p1_gnt one cycle later; p1_done one cycle after ctl_done.
REQ-030 Simultaneous requests, macro undefined: both held 20 bursts -> all 20 grants to port 0, port 1 never granted.
REQ-031 Simultaneous requests, macro defined, STARVE_MAX=8: both held -> grant sequence 8x port 0, 1x port 1, repeating.
REQ-032 Backpressure: ctl_ready low 5 cycles -> ctl_valid held 5 cycles with constant addr; exactly one gnt pulse.
REQ-033 Reset asserted in WAIT -> busy=0 and ctl_valid=0 immediately, no done pulse; subsequent p0_req serviced normally.
REQ-034 Spurious ctl_done in IDLE -> no done pulse, state stays IDLE.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM arbiter: state encoding and default address width.
package psram_pkg;

    localparam int ADDR_W_DEFAULT = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/psram_arb.sv
// Two-port burst arbiter in front of a PSRAM controller; port 0 (display refill) has priority.
// Optional starvation guard for port 1 is enabled with the PSRAM_ARB_STARVE_EN macro.
module psram_arb
    import psram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_wr,
    output logic              p0_gnt,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_wr,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              ctl_valid,
    input  logic              ctl_ready,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic              ctl_wr,
    input  logic              ctl_done,
    output logic              busy
);

    state_t state_reg, state_next;
    logic   winner_reg;
    logic   pick_p1;
    logic   any_req;
    logic   accept;
    logic   finish;

    assign any_req   = p0_req | p1_req;
    assign accept    = (state_reg == ISSUE) & ctl_ready;
    assign finish    = (state_reg == WAIT) & ctl_done;
    assign ctl_valid = (state_reg == ISSUE);
    assign busy      = (state_reg != IDLE);

    // A zero limit would make the guard meaningless; kept as a named block for elaboration visibility.
    if (STARVE_MAX < 1) begin : g_starve_max_invalid
    end

`ifdef PSRAM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_reg;

    assign pick_p1 = p1_req & (~p0_req | (starve_reg == CNT_W'(STARVE_MAX)));

    // Counts port-0 grants taken while port 1 is kept waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_reg <= '0;
        end else if ((accept & winner_reg) | ~p1_req) begin
            starve_reg <= '0;
        end else if (accept & ~winner_reg & (starve_reg != CNT_W'(STARVE_MAX))) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end
`else
    assign pick_p1 = p1_req & ~p0_req;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req)   state_next = ISSUE;
            ISSUE:   if (ctl_ready) state_next = WAIT;
            WAIT:    if (ctl_done)  state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            winner_reg <= 1'b0;
            ctl_addr   <= '0;
            ctl_wr     <= 1'b0;
            p0_gnt     <= 1'b0;
            p1_gnt     <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
        end else begin
            state_reg <= state_next;
            p0_gnt    <= accept & ~winner_reg;
            p1_gnt    <= accept & winner_reg;
            p0_done   <= finish & ~winner_reg;
            p1_done   <= finish & winner_reg;
            if ((state_reg == IDLE) && any_req) begin
                winner_reg <= pick_p1;
                ctl_addr   <= pick_p1 ? p1_addr : p0_addr;
                ctl_wr     <= pick_p1 ? p1_wr : p0_wr;
            end
        end
    end

endmodule

// File: tb/tb_psram_arb.sv
// Self-checking bench for psram_arb: table-driven single bursts plus hand-written corner sequences.
module tb_psram_arb;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_wr, p0_gnt, p0_done;
    logic          p1_req, p1_wr, p1_gnt, p1_done;
    logic [AW-1:0] p0_addr, p1_addr, ctl_addr;
    logic          ctl_valid, ctl_ready, ctl_wr, ctl_done, busy;

    int total = 0;
    int bad   = 0;
    int gnt_cnt0 = 0;
    int gnt_cnt1 = 0;

    typedef struct packed {
        logic          port;
        logic [AW-1:0] addr;
        logic          wr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          r0, r1;
        logic [AW-1:0] a0, a1;
        logic          w0, w1;
        int            rdy_lat;
        int            done_lat;
        logic          e_port;
        logic [AW-1:0] e_addr;
        logic          e_wr;
    } vec_t;

    psram_arb #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wr(p0_wr), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wr(p1_wr), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_addr(ctl_addr), .ctl_wr(ctl_wr),
        .ctl_done(ctl_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every grant pulse must match the oldest expected command.
    always @(negedge clk) begin
        if (!reset && (p0_gnt || p1_gnt)) begin
            exp_t e;
            check("gnt_exclusive", {31'd0, p0_gnt & p1_gnt}, 32'd0);
            if (sb.size() == 0) begin
                check("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("gnt_port", {31'd0, p1_gnt}, {31'd0, e.port});
                check("gnt_addr", {10'd0, ctl_addr}, {10'd0, e.addr});
                check("gnt_wr", {31'd0, ctl_wr}, {31'd0, e.wr});
            end
            $display("grant port=%0d addr=0x%06h wr=%0d", p1_gnt, ctl_addr, ctl_wr);
            if (p0_gnt) gnt_cnt0++;
            if (p1_gnt) gnt_cnt1++;
        end
        if (!reset) check("done_exclusive", {31'd0, p0_done & p1_done}, 32'd0);
    end

    task automatic do_burst(input vec_t v);
        int   g_before;
        logic [AW-1:0] held;
        p0_req = v.r0; p0_addr = v.a0; p0_wr = v.w0;
        p1_req = v.r1; p1_addr = v.a1; p1_wr = v.w1;
        ctl_ready = 1'b0;
        sb.push_back('{v.e_port, v.e_addr, v.e_wr});
        g_before = gnt_cnt0 + gnt_cnt1;
        tick();
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("issue_valid", {31'd0, ctl_valid}, 32'd1);
        check("issue_addr", {10'd0, ctl_addr}, {10'd0, v.e_addr});
        check("issue_wr", {31'd0, ctl_wr}, {31'd0, v.e_wr});
        check("issue_busy", {31'd0, busy}, 32'd1);
        held = ctl_addr;
        for (int i = 0; i < v.rdy_lat; i++) begin
            tick();
            check("bp_valid", {31'd0, ctl_valid}, 32'd1);
            check("bp_addr", {10'd0, ctl_addr}, {10'd0, held});
        end
        ctl_ready = 1'b1;
        tick();
        ctl_ready = 1'b0;
        check("wait_valid", {31'd0, ctl_valid}, 32'd0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < v.done_lat; i++) begin
            tick();
            check("wait_no_done", {30'd0, p1_done, p0_done}, 32'd0);
        end
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        check("done_pulse", {30'd0, p1_done, p0_done}, v.e_port ? 32'd2 : 32'd1);
        check("done_idle", {31'd0, busy}, 32'd0);
        tick();
        check("done_once", {30'd0, p1_done, p0_done}, 32'd0);
        check("gnt_once", gnt_cnt0 + gnt_cnt1, g_before + 1);
        $display("burst port=%0d addr=0x%06h wr=%0d rdy_lat=%0d done_lat=%0d",
                 v.e_port, v.e_addr, v.e_wr, v.rdy_lat, v.done_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n, g1_before, n_bursts;
        logic exp_p;
        vecs[0] = '{1'b0, 1'b1, 22'h000000, 22'h000100, 1'b0, 1'b1, 0, 0, 1'b1, 22'h000100, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 22'h3FFFFF, 22'h000000, 1'b0, 1'b0, 0, 1, 1'b0, 22'h3FFFFF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 22'h012345, 22'h02AAAA, 1'b1, 1'b0, 1, 0, 1'b0, 22'h012345, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 22'h000055, 22'h000000, 1'b1, 1'b0, 5, 0, 1'b0, 22'h000055, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 22'h000000, 22'h000000, 1'b0, 1'b0, 0, 3, 1'b1, 22'h000000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 22'h00ABCD, 22'h03F000, 1'b0, 1'b1, 2, 2, 1'b0, 22'h00ABCD, 1'b0};

        reset = 1'b1;
        p0_req = 0; p1_req = 0; p0_addr = '0; p1_addr = '0; p0_wr = 0; p1_wr = 0;
        ctl_ready = 0; ctl_done = 0;
        tick();
        tick();
        check("rst_outputs", {26'd0, ctl_valid, busy, p0_gnt, p1_gnt, p0_done, p1_done}, 32'd0);
        check("rst_addr", {9'd0, ctl_wr, ctl_addr}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) do_burst(vecs[i]);

        // Spurious ctl_done while idle.
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        check("spur_idle_done", {30'd0, p1_done, p0_done}, 32'd0);
        check("spur_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("spur_idle_stay", {30'd0, busy, p0_done | p1_done}, 32'd0);
        $display("spurious ctl_done in IDLE ignored");

        // ctl_done during ISSUE must not end the command.
        p1_req = 1'b1; p1_addr = 22'h000222; p1_wr = 1'b0;
        sb.push_back('{1'b1, 22'h000222, 1'b0});
        tick();
        p1_req = 1'b0;
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        check("issue_done_ignored", {29'd0, ctl_valid, p1_done, p0_done}, 32'd4);
        ctl_ready = 1'b1;
        tick();
        ctl_ready = 1'b0;
        check("issue_done_wait", {30'd0, busy, ctl_valid}, 32'd2);
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        check("issue_done_final", {30'd0, p1_done, p0_done}, 32'd2);
        tick();
        $display("ctl_done in ISSUE ignored");

        // Reset while waiting for the burst to finish.
        p0_req = 1'b1; p0_addr = 22'h000777; p0_wr = 1'b1;
        sb.push_back('{1'b0, 22'h000777, 1'b1});
        tick();
        p0_req = 1'b0;
        ctl_ready = 1'b1;
        tick();
        ctl_ready = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_wait_busy", {31'd0, busy}, 32'd0);
        check("rst_wait_valid", {31'd0, ctl_valid}, 32'd0);
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        reset = 1'b0;
        check("rst_wait_no_done", {30'd0, p1_done, p0_done}, 32'd0);
        tick();
        check("rst_wait_no_done2", {29'd0, busy, p1_done, p0_done}, 32'd0);
        $display("reset in WAIT discarded burst");
        do_burst('{1'b1, 1'b0, 22'h001234, 22'h0, 1'b0, 1'b0, 0, 0, 1'b0, 22'h001234, 1'b0});

        // Both ports requesting continuously.
`ifdef PSRAM_ARB_STARVE_EN
        n_bursts = 27;
`else
        n_bursts = 20;
`endif
        g1_before = gnt_cnt1;
        p0_req = 1'b1; p0_addr = 22'h001000; p0_wr = 1'b0;
        p1_req = 1'b1; p1_addr = 22'h002000; p1_wr = 1'b1;
        ctl_ready = 1'b1;
        for (int k = 0; k < n_bursts; k++) begin
`ifdef PSRAM_ARB_STARVE_EN
            exp_p = ((k % 9) == 8);
`else
            exp_p = 1'b0;
`endif
            sb.push_back(exp_p ? exp_t'{1'b1, 22'h002000, 1'b1} : exp_t'{1'b0, 22'h001000, 1'b0});
            n = 0;
            do begin
                tick();
                n++;
            end while (!(p0_gnt || p1_gnt) && n < 10);
            check("prio_gnt_seen", {31'd0, n < 10}, 32'd1);
            ctl_done = 1'b1;
            tick();
            ctl_done = 1'b0;
            check("prio_done", {30'd0, p1_done, p0_done}, exp_p ? 32'd2 : 32'd1);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        ctl_ready = 1'b0;
        tick();
        tick();
`ifdef PSRAM_ARB_STARVE_EN
        check("prio_p1_count", gnt_cnt1 - g1_before, 32'd3);
`else
        check("prio_p1_count", gnt_cnt1 - g1_before, 32'd0);
`endif
        $display("priority run: %0d bursts, port1 grants=%0d", n_bursts, gnt_cnt1 - g1_before);

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
